// File: rtl/serial_fa_adder.sv
// Bit-serial add/subtract unit: a single full-adder cell is fed one operand
// bit pair per clock, LSB first, and the result is shifted in from the top.
`timescale 1ns/1ps

module serial_fa_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  assign fa_s = sa_q[0] ^ sb_q[0] ^ carry_q;
  assign fa_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);

  // A start arriving while done is high is dropped, so back-to-back
  // requests only launch once the bench/host holds start into true IDLE.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          sa_d    = op_a;
          sb_d    = sub ? ~op_b : op_b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        sa_d    = {1'b0, sa_q[WIDTH-1:1]};
        sb_d    = {1'b0, sb_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (cnt_q == LAST) begin
          cin_msb_d = carry_q;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        sum_d   = res_q;
        cout_d  = carry_q;
        ovf_d   = cin_msb_q ^ carry_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sa_q      <= '0;
      sb_q      <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_fa_adder.sv
// Bench for serial_fa_adder: arithmetic reference model with a cycle-level
// timing model, directed corner operations and randomized traffic.
`timescale 1ns/1ps

module tb_serial_fa_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int errors = 0;
  int checks = 0;
  logic chkEn = 1'b0;

  serial_fa_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain arithmetic reference: returns {overflow, cout, sum}.
  function automatic logic [W+1:0] refResult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic [W-1:0] r;
    logic         ov;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
    r    = full[W-1:0];
    if (s) ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    else   ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {ov, full[W], r};
  endfunction

  // Timing model: an accepted op keeps the unit busy for W+1 cycles and the
  // result appears with the done pulse on the following edge.
  int           mLeft;
  logic         mDone;
  logic [W-1:0] mSum;
  logic         mCout;
  logic         mOvf;
  logic [W+1:0] mPend;
  logic         wasDone;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mLeft = 0;
      mDone = 1'b0;
      mSum  = '0;
      mCout = 1'b0;
      mOvf  = 1'b0;
    end else begin
      wasDone = mDone;
      mDone   = 1'b0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mDone = 1'b1;
          {mOvf, mCout, mSum} = mPend;
        end
      end else if (start && !wasDone) begin
        mPend = refResult(sub, op_a, op_b);
        mLeft = W + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("model.busy", 32'(busy), 32'(mLeft > 0));
      checkOutput("model.done", 32'(done), 32'(mDone));
      checkOutput("model.sum", 32'(sum), 32'(mSum));
      checkOutput("model.cout", 32'(cout), 32'(mCout));
      checkOutput("model.overflow", 32'(overflow), 32'(mOvf));
    end
  end

  // Returns at the negedge just after the edge that samples start.
  task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int lat, output int busyN);
    lat   = 0;
    busyN = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busyN++;
    end
    if (!done) checkOutput("doneTimeout", 32'(done), 32'd1);
  endtask

  task automatic directedOp(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] eSum, input logic eCout, input logic eOvf);
    int lat;
    int busyN;
    applyStimulus(s, a, b);
    waitDone(lat, busyN);
    checkOutput({tag, ".sum"}, 32'(sum), 32'(eSum));
    checkOutput({tag, ".cout"}, 32'(cout), 32'(eCout));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(eOvf));
    checkOutput({tag, ".latency"}, 32'(lat), 32'(W + 1));
    checkOutput({tag, ".busyCycles"}, 32'(busyN), 32'(W + 1));
  endtask

  initial begin
    int lat;
    int busyN;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(negedge clk);
    chkEn = 1'b1;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    directedOp("add3C25", 1'b0, 8'h3C, 8'h25, 8'h61, 1'b0, 1'b0);
    directedOp("addFF01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    directedOp("add7F01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    directedOp("sub0507", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    directedOp("sub8001", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Start pulses while busy and on the done cycle must be ignored.
    applyStimulus(1'b0, 8'h10, 8'h20);
    repeat (2) @(negedge clk);
    start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    waitDone(lat, busyN);
    checkOutput("ignore.sum", 32'(sum), 32'h30);
    start = 1'b1; sub = 1'b0; op_a = 8'hAA; op_b = 8'h55;
    @(negedge clk);
    checkOutput("ignore.doneCycleStart", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("ignore.heldStartAccepted", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone(lat, busyN);
    checkOutput("ignore.secondSum", 32'(sum), 32'hFF);

    // Reset in the middle of an operation.
    applyStimulus(1'b0, 8'h3C, 8'h25);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    checkOutput("midReset.sum", 32'(sum), 32'd0);
    checkOutput("midReset.cout", 32'(cout), 32'd0);
    checkOutput("midReset.overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    directedOp("afterReset", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

    // Randomized traffic with noise on the inputs while busy.
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(1'(($urandom_range(0, 1))), W'($urandom), W'($urandom));
      lat = 0;
      while (!done && lat < 40) begin
        start = 1'(($urandom_range(0, 3) == 0));
        sub   = 1'(($urandom_range(0, 1)));
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        @(negedge clk);
        lat++;
      end
      start = 1'b0;
      if (!done) checkOutput("random.doneTimeout", 32'(done), 32'd1);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
